// File: rtl/fp_regfile_sb.sv
// rtl/fp_regfile_sb.sv - FP register file f0-f31 with pending-write scoreboard and hazard stall.
// Optional writeback-to-read forwarding enabled by defining FP_RF_WB_BYPASS_EN.
module fp_regfile_sb #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rs3_addr,
  input  logic [2:0]       rs_use,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  rs3_data,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             issue_valid,
  input  logic             issue_wr,
  input  logic [4:0]       issue_rd,
  input  logic             flush,
  output logic             hazard_stall,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_eff;
  logic [NREGS-1:0] wb_onehot;
  logic [NREGS-1:0] issue_onehot;
  logic             accept;

  always_comb begin
    wb_onehot = '0;
    if (wb_en) wb_onehot[wb_rd] = 1'b1;
  end

`ifdef FP_RF_WB_BYPASS_EN
  // A producer writing back this cycle no longer blocks its consumers.
  assign busy_eff = busy_q & ~wb_onehot;
  assign rs1_data = (wb_en && (rs1_addr == wb_rd)) ? wb_data : regs_q[rs1_addr];
  assign rs2_data = (wb_en && (rs2_addr == wb_rd)) ? wb_data : regs_q[rs2_addr];
  assign rs3_data = (wb_en && (rs3_addr == wb_rd)) ? wb_data : regs_q[rs3_addr];
`else
  assign busy_eff = busy_q;
  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign rs3_data = regs_q[rs3_addr];
`endif

  assign hazard_stall = issue_valid & ((rs_use[0] & busy_eff[rs1_addr]) |
                                       (rs_use[1] & busy_eff[rs2_addr]) |
                                       (rs_use[2] & busy_eff[rs3_addr]) |
                                       (issue_wr  & busy_eff[issue_rd]));
  assign accept   = issue_valid & ~hazard_stall & issue_wr;
  assign busy_vec = busy_q;

  always_comb begin
    issue_onehot = '0;
    if (accept) issue_onehot[issue_rd] = 1'b1;
  end

  // Set is applied after clear so a new producer keeps ownership of the register.
  always_comb begin
    busy_d = flush ? '0 : ((busy_q & ~wb_onehot) | issue_onehot);
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb/tb_fp_regfile_sb.sv - self-checking bench for fp_regfile_sb against a behavioural model.
module tb_fp_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
  logic [2:0]  rs_use;
  logic [31:0] rs1_data, rs2_data, rs3_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        issue_valid, issue_wr;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        hazard_stall;
  logic [31:0] busy_vec;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  fp_regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .rs_use(rs_use),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .flush(flush), .hazard_stall(hazard_stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy_eff(input logic [4:0] r);
    bit b;
    b = m_busy[r];
`ifdef FP_RF_WB_BYPASS_EN
    if (wb_en && wb_rd == r) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
`ifdef FP_RF_WB_BYPASS_EN
    if (wb_en && wb_rd == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    if (rs_use[0] && m_busy_eff(rs1_addr)) return 1'b1;
    if (rs_use[1] && m_busy_eff(rs2_addr)) return 1'b1;
    if (rs_use[2] && m_busy_eff(rs3_addr)) return 1'b1;
    if (issue_wr && m_busy_eff(issue_rd)) return 1'b1;
    return 1'b0;
  endfunction

  // Model state update on each rising edge.
  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_busy = 32'h0;
    end else begin
      acc = m_stall() == 1'b0 && issue_valid && issue_wr;
      if (wb_en) m_regs[wb_rd] = wb_data;
      if (flush) m_busy = 32'h0;
      else begin
        if (wb_en) m_busy[wb_rd] = 1'b0;
        if (acc) m_busy[issue_rd] = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cyc_rs1", rs1_data, m_read(rs1_addr));
      cmp("cyc_rs2", rs2_data, m_read(rs2_addr));
      cmp("cyc_rs3", rs3_data, m_read(rs3_addr));
      cmp("cyc_stall", {31'h0, hazard_stall}, {31'h0, m_stall()});
      cmp("cyc_busy", busy_vec, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 0; issue_valid = 0; issue_wr = 0; flush = 0; rs_use = 3'b000;
  endtask

  task automatic accept_rd(input logic [4:0] r);
    issue_valid = 1; issue_wr = 1; issue_rd = r; rs_use = 3'b000;
    tick();
    idle();
  endtask

  initial begin
    rst_n = 0; rs1_addr = 0; rs2_addr = 0; rs3_addr = 0; issue_rd = 0;
    wb_rd = 0; wb_data = 0;
    idle();
    tick(); tick();
    rst_n = 1;
    #1;
    chk_en = 1'b1;

    rs1_addr = 0; rs2_addr = 17; rs3_addr = 31;
    #1;
    cmp("rst_f0", rs1_data, 32'h0);
    cmp("rst_f17", rs2_data, 32'h0);
    cmp("rst_f31", rs3_data, 32'h0);
    cmp("rst_busy", busy_vec, 32'h0);
    cmp("rst_stall", {31'h0, hazard_stall}, 32'h0);

    wb_en = 1; wb_rd = 5; wb_data = 32'h3F80_0000; rs1_addr = 5;
    #1;
`ifdef FP_RF_WB_BYPASS_EN
    cmp("bypass_same_cycle", rs1_data, 32'h3F80_0000);
`else
    cmp("no_bypass_same_cycle", rs1_data, 32'h0);
`endif
    tick();
    idle();
    #1;
    cmp("wr_visible", rs1_data, 32'h3F80_0000);

    accept_rd(3);
    cmp("busy_f3", busy_vec, 32'h0000_0008);
    issue_valid = 1; issue_wr = 0; rs2_addr = 3; rs_use = 3'b010;
    #1;
    cmp("raw_stall", {31'h0, hazard_stall}, 32'h1);
    wb_en = 1; wb_rd = 3; wb_data = 32'h4000_0000;
    #1;
`ifdef FP_RF_WB_BYPASS_EN
    cmp("wb_cycle_stall", {31'h0, hazard_stall}, 32'h0);
`else
    cmp("wb_cycle_stall", {31'h0, hazard_stall}, 32'h1);
`endif
    tick();
    wb_en = 0;
    #1;
    cmp("post_wb_stall", {31'h0, hazard_stall}, 32'h0);
    cmp("post_wb_busy", busy_vec, 32'h0);
    cmp("post_wb_rs2", rs2_data, 32'h4000_0000);
    idle();

    issue_valid = 1; issue_wr = 1; issue_rd = 7; wb_en = 1; wb_rd = 7; wb_data = 32'h1111_1111;
    tick();
    idle();
    cmp("set_wins_b7", {31'h0, busy_vec[7]}, 32'h1);
    wb_en = 1; wb_rd = 7; tick(); idle();
    accept_rd(8);
    cmp("busy_f8", busy_vec, 32'h0000_0100);
    issue_valid = 1; issue_wr = 1; issue_rd = 7; wb_en = 1; wb_rd = 8; wb_data = 32'h2222_2222;
    tick();
    idle();
    cmp("indep_b7", {31'h0, busy_vec[7]}, 32'h1);
    cmp("indep_b8", {31'h0, busy_vec[8]}, 32'h0);

    issue_valid = 1; issue_wr = 1; issue_rd = 7; rs_use = 3'b000;
    #1;
    cmp("waw_stall", {31'h0, hazard_stall}, 32'h1);
    idle();

    flush = 1; tick(); idle();
    cmp("flush_clear", busy_vec, 32'h0);
    for (int r = 4; r < 8; r++) accept_rd(5'(r));
    cmp("busy_f0", busy_vec, 32'h0000_00F0);
    flush = 1; issue_valid = 1; issue_wr = 1; issue_rd = 2;
    wb_en = 1; wb_rd = 10; wb_data = 32'h1234_5678;
    tick();
    idle();
    rs3_addr = 10;
    #1;
    cmp("flush_busy", busy_vec, 32'h0);
    cmp("flush_wb_write", rs3_data, 32'h1234_5678);

    for (int r = 0; r < 32; r++) accept_rd(5'(r));
    wb_en = 1; wb_rd = 9; wb_data = 32'hC000_0000;
    tick();
    idle();
    issue_valid = 1; issue_wr = 0; rs1_addr = 9;
    #1;
    cmp("all_busy_after_wb9", busy_vec, 32'hFFFF_FDFF);
    cmp("f9_written", rs1_data, 32'hC000_0000);
    idle();
    accept_rd(9);
    cmp("all_busy", busy_vec, 32'hFFFF_FFFF);

    rst_n = 0; flush = 1; wb_en = 1; wb_rd = 9; wb_data = 32'hDEAD_BEEF;
    issue_valid = 1; issue_wr = 1; issue_rd = 1;
    tick();
    rst_n = 1;
    idle();
    issue_valid = 1; rs_use = 3'b111; rs1_addr = 9; rs2_addr = 5; rs3_addr = 31;
    #1;
    cmp("rst2_busy", busy_vec, 32'h0);
    cmp("rst2_f9", rs1_data, 32'h0);
    cmp("rst2_f5", rs2_data, 32'h0);
    cmp("rst2_stall", {31'h0, hazard_stall}, 32'h0);
    idle();
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
- Floating-point architectural register file (f0–f31) with a pending-write scoreboard.
- Sits between the FP decode/issue stage and the FP writeback stage.
- Consumes the writeback stage's registered write port (rd, data, write enable).
- Supplies three combinational read ports (rs1/rs2/rs3 for fused multiply-add) and raises a RAW/WAW hazard stall for the issue stage.

Parameters:
- NREGS, 32, number of FP registers (address width fixed at 5).
- XLEN, 32, register data width (single precision).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- rs1_addr  input  5  read port 1 address
- rs2_addr  input  5  read port 2 address
- rs3_addr  input  5  read port 3 address
- rs_use  input  3  bit i set = source rs(i+1) used by the instruction at issue
- rs1_data  output  32  read port 1 data
- rs2_data  output  32  read port 2 data
- rs3_data  output  32  read port 3 data
- wb_en  input  1  writeback write enable, from FP writeback stage
- wb_rd  input  5  writeback destination register
- wb_data  input  32  writeback data (FPU result or FP load)
- issue_valid  input  1  instruction presented at issue
- issue_wr  input  1  issuing instruction writes an FP register
- issue_rd  input  5  destination of the issuing instruction
- flush  input  1  pipeline flush; abandons all in-flight producers
- hazard_stall  output  1  issue must hold; instruction not accepted
- busy_vec  output  32  scoreboard state, bit n = fn has a pending write

Behaviour:
- Reset (rst_n=0 at a clock edge): all 32 registers are set to 32'h0 and busy_vec to 0. hazard_stall is combinational and reads 0 while issue_valid=0.
- f0 is an ordinary writable register. There is no hardwired zero.
- Reads are combinational from the array; zero-cycle latency.
- Write: on the clock edge with wb_en=1, reg[wb_rd] <= wb_data. The write is visible on the read ports the following cycle (see Optional Feature). Writing a non-busy register is legal and still writes.
- Hazard (combinational): hazard_stall = issue_valid & ((rs_use[0]&busy_eff[rs1_addr]) | (rs_use[1]&busy_eff[rs2_addr]) | (rs_use[2]&busy_eff[rs3_addr]) | (issue_wr&busy_eff[issue_rd])). busy_eff = busy_vec without the feature.
- Issue accept: an accept occurs when issue_valid=1, hazard_stall=0 and issue_wr=1; on that edge busy[issue_rd] <= 1.
- Writeback clear: on an edge with wb_en=1, busy[wb_rd] <= 0.
- Simultaneous accept and clear on the same register: set wins, and busy stays 1 (new producer owns it). Different registers update independently.
- Flush: on an edge with flush=1, all busy bits are cleared and any accept in that cycle is ignored. A wb_en write in the flush cycle still updates the array.
- Reset mid-operation: rst_n dominates flush, wb_en and issue; all state returns to reset values on that edge.
- Register array and scoreboard are the only state. No other storage.

Optional Feature:
- Macro: FP_RF_WB_BYPASS_EN.
- Defined:
  - Each read port returns wb_data when wb_en=1 and the port address equals wb_rd; otherwise the array value.
  - busy_eff = busy_vec & ~(wb_en ? onehot(wb_rd) : 0), so a consumer issues in the same cycle its producer writes back.
- Undefined:
  - No forwarding; reads always return the array.
  - busy_eff = busy_vec, so a dependent instruction stalls through the writeback cycle and issues one cycle later.

Test Plan:
- Reset, then read f0, f17, f31 → all 32'h0; busy_vec=0; hazard_stall=0.
- wb_en=1, wb_rd=5, wb_data=32'h3F800000 → next cycle rs1_addr=5 reads 32'h3F800000. With the bypass feature, the read returns 32'h3F800000 in the write cycle itself.
- Issue issue_wr=1, issue_rd=3 → busy_vec=32'h8. Next issue with rs2_addr=3, rs_use=3'b010 → hazard_stall=1. Then wb_en/wb_rd=3:
  - with bypass: stall drops in that cycle;
  - without bypass: stall drops the next cycle.
  - busy_vec returns to 0.
- Same edge: accept issue_rd=7 and wb_en with wb_rd=7 → busy_vec bit 7 = 1 afterward. Same edge with wb_rd=8 instead → bit 7 = 1, bit 8 = 0.
- busy_vec=32'h0000_00F0, then flush=1 together with an accept of issue_rd=2 → busy_vec=0 next cycle.
- Assert rst_n=0 while busy_vec=32'hFFFF_FFFF and f9=32'hC0000000 → next cycle busy_vec=0, f9=0, hazard_stall=0.
